// File: rtl/axil_mem_test_master.sv
// axil_mem_test_master: AXI-Lite memory self-test master.
// On a start pulse it writes NUM_WORDS seeded patterns starting at BASE_ADDR, one at a time.
// It then reads every word back and counts mismatches and error responses.
// It reports the result on done/pass/err_count/leds.
//
// Ports:
//   ACLK, ARESET        - sole clock (rising edge), synchronous active-high reset
//   start               - pulse; accepted only in IDLE or FIN
//   busy, done, pass    - status; leds = {done, pass, ~pass & done, busy}
//   timeout             - watchdog expired (always 0 unless AXIL_MEM_TEST_TIMEOUT_EN)
//   err_count           - saturating count of data mismatches and non-OKAY responses
//   M_AXI_*             - AXI-Lite master write (AW/W/B) and read (AR/R) channels
//
// Build option: define AXIL_MEM_TEST_TIMEOUT_EN to add a 1024-cycle per-state watchdog.
module axil_mem_test_master #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h4000_0000),
  parameter int unsigned       NUM_WORDS = 16,
  parameter logic [31:0]       SEED      = 32'hDEADBEEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_count,
  output logic [3:0]          leds,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrReq  = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;
  localparam logic [2:0] StFin    = 3'd5;

  localparam int unsigned StrbW   = DATA_W / 8;
  localparam logic [15:0] LastIdx = 16'(NUM_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] err_q, err_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        timeout_q;
  logic        wd_fire;
  logic        start_ok;
  logic        err_inc;

  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       pat_word;
  logic [DATA_W-1:0] pattern;

  assign word_addr = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(StrbW);
  assign pat_word  = SEED ^ {16'h0000, idx_q};
  assign pattern   = {(DATA_W / 32){pat_word}};

  assign busy     = (state_q == StWrReq) || (state_q == StWrResp) ||
                    (state_q == StRdReq) || (state_q == StRdData);
  assign start_ok = start && ((state_q == StIdle) || (state_q == StFin));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    done_d    = done_q;
    pass_d    = pass_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    err_inc   = 1'b0;

    case (state_q)
      StIdle, StFin: begin
        if (start) begin
          err_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          idx_d     = '0;
          state_d   = StWrReq;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      StWrReq: begin
        // Each valid drops independently after its own handshake.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = StWrResp;
      end
      StWrResp: begin
        if (M_AXI_BVALID) begin
          err_inc = (M_AXI_BRESP != 2'b00);
          if (idx_q == LastIdx) begin
            idx_d     = '0;
            state_d   = StRdReq;
            arvalid_d = 1'b1;
          end else begin
            idx_d     = idx_q + 16'd1;
            state_d   = StWrReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      StRdReq: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (M_AXI_RVALID) begin
          err_inc = (M_AXI_RDATA != pattern) || (M_AXI_RRESP != 2'b00);
          if (idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            idx_d     = idx_q + 16'd1;
            state_d   = StRdReq;
            arvalid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;

    if (wd_fire) begin
      state_d   = StFin;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
    end

    // Verdict is latched once, on the cycle FIN is entered.
    if ((state_d == StFin) && (state_q != StFin)) begin
      done_d = 1'b1;
      pass_d = (err_d == 16'h0000) && !wd_fire;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
    end
  end

`ifdef AXIL_MEM_TEST_TIMEOUT_EN
  // Counts cycles spent in the current busy state; restarts on every state change.
  logic [9:0] wd_q, wd_d;
  logic       timeout_d;

  assign wd_fire = busy && (wd_q == 10'd1023);

  always_comb begin
    wd_d      = ((state_d != state_q) || !busy) ? 10'd0 : wd_q + 10'd1;
    timeout_d = timeout_q;
    if (start_ok)     timeout_d = 1'b0;
    else if (wd_fire) timeout_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign wd_fire         = 1'b0;
  assign timeout_q       = 1'b0;
`endif

  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_count = err_q;
  assign leds      = {done_q, pass_q, ~pass_q & done_q, busy};

  // Address/data are driven only while their valid is up so that reset leaves every output at 0.
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = awvalid_q ? word_addr : '0;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wvalid_q ? pattern : '0;
  assign M_AXI_WSTRB   = wvalid_q ? '1 : '0;
  assign M_AXI_BREADY  = (state_q == StWrResp);
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = arvalid_q ? word_addr : '0;
  assign M_AXI_RREADY  = (state_q == StRdData);

endmodule

// File: tb/tb_axil_mem_test_master.sv
module tb_axil_mem_test_master;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- DUT A: defaults (32-bit, 16 words) ----------------
  logic        start_a;
  logic        busy_a, done_a, pass_a, timeout_a;
  logic [15:0] err_a;
  logic [3:0]  leds_a;
  logic [31:0] awaddr_a, wdata_a, araddr_a, rdata_a;
  logic [3:0]  wstrb_a;
  logic        awvalid_a, wvalid_a, bready_a, arvalid_a, rready_a;
  logic        bvalid_a, rvalid_a, arready_a;
  logic [1:0]  bresp_mode_a;
  logic        ar_stall_a;
  int          corrupt_a;

  assign arready_a = ~ar_stall_a;

  axil_mem_test_master u_dut_a (
    .ACLK(clk), .ARESET(areset), .start(start_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
    .err_count(err_a), .leds(leds_a),
    .M_AXI_AWADDR(awaddr_a), .M_AXI_AWVALID(awvalid_a), .M_AXI_AWREADY(1'b1),
    .M_AXI_WDATA(wdata_a), .M_AXI_WSTRB(wstrb_a), .M_AXI_WVALID(wvalid_a),
    .M_AXI_WREADY(1'b1), .M_AXI_BRESP(bresp_mode_a), .M_AXI_BVALID(bvalid_a),
    .M_AXI_BREADY(bready_a), .M_AXI_ARADDR(araddr_a), .M_AXI_ARVALID(arvalid_a),
    .M_AXI_ARREADY(arready_a), .M_AXI_RDATA(rdata_a), .M_AXI_RRESP(2'b00),
    .M_AXI_RVALID(rvalid_a), .M_AXI_RREADY(rready_a)
  );

  // ---------------- DUT B: 64-bit, 4 words ----------------
  logic        start_b;
  logic        busy_b, done_b, pass_b, timeout_b;
  logic [15:0] err_b;
  logic [3:0]  leds_b;
  logic [31:0] awaddr_b, araddr_b;
  logic [63:0] wdata_b, rdata_b;
  logic [7:0]  wstrb_b;
  logic        awvalid_b, wvalid_b, bready_b, arvalid_b, rready_b;
  logic        awready_b, bvalid_b, rvalid_b;

  axil_mem_test_master #(.DATA_W(64), .NUM_WORDS(4)) u_dut_b (
    .ACLK(clk), .ARESET(areset), .start(start_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
    .err_count(err_b), .leds(leds_b),
    .M_AXI_AWADDR(awaddr_b), .M_AXI_AWVALID(awvalid_b), .M_AXI_AWREADY(awready_b),
    .M_AXI_WDATA(wdata_b), .M_AXI_WSTRB(wstrb_b), .M_AXI_WVALID(wvalid_b),
    .M_AXI_WREADY(1'b1), .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bvalid_b),
    .M_AXI_BREADY(bready_b), .M_AXI_ARADDR(araddr_b), .M_AXI_ARVALID(arvalid_b),
    .M_AXI_ARREADY(1'b1), .M_AXI_RDATA(rdata_b), .M_AXI_RRESP(2'b00),
    .M_AXI_RVALID(rvalid_b), .M_AXI_RREADY(rready_b)
  );

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp_waddr_a[$], obs_waddr_a[$], exp_raddr_a[$], obs_raddr_a[$];
  logic [63:0] exp_wdata_a[$], obs_wdata_a[$];
  logic [31:0] exp_waddr_b[$], obs_waddr_b[$], exp_raddr_b[$], obs_raddr_b[$];
  logic [63:0] exp_wdata_b[$], obs_wdata_b[$];
  logic [31:0] first_wstrb_a;

  // ---------------- slave A: zero-wait memory ----------------
  logic [31:0] mem_a [64];
  logic        aw_got_a, w_got_a;
  logic [31:0] aw_q_a, w_q_a;
  logic [31:0] woff_a, roff_a;
  assign woff_a = aw_q_a - 32'h4000_0000;
  assign roff_a = araddr_a - 32'h4000_0000;

  always @(posedge clk) begin
    if (areset) begin
      aw_got_a <= 1'b0; w_got_a <= 1'b0; bvalid_a <= 1'b0; rvalid_a <= 1'b0;
      rdata_a  <= '0;
    end else begin
      if (aw_got_a && w_got_a && !bvalid_a) begin
        mem_a[woff_a[7:2]] <= w_q_a;
        obs_waddr_a.push_back(aw_q_a);
        obs_wdata_a.push_back({32'h0, w_q_a});
        bvalid_a <= 1'b1; aw_got_a <= 1'b0; w_got_a <= 1'b0;
      end
      if (awvalid_a) begin aw_got_a <= 1'b1; aw_q_a <= awaddr_a; end
      if (wvalid_a) begin
        w_got_a <= 1'b1; w_q_a <= wdata_a; first_wstrb_a <= {28'h0, wstrb_a};
      end
      if (bvalid_a && bready_a) bvalid_a <= 1'b0;
      if (rvalid_a && rready_a) rvalid_a <= 1'b0;
      if (arvalid_a && arready_a) begin
        obs_raddr_a.push_back(araddr_a);
        rdata_a  <= (int'(roff_a[7:2]) == corrupt_a) ? 32'h0 : mem_a[roff_a[7:2]];
        rvalid_a <= 1'b1;
      end
    end
  end

  // ---------------- slave B: AWREADY lags the W handshake ----------------
  logic [63:0] mem_b [8];
  logic        aw_got_b, w_got_b, hold_b, stab_err_b;
  logic [31:0] aw_q_b, held_addr_b, woff_b, roff_b;
  logic [63:0] w_q_b;
  logic [2:0]  dly_b;
  int          stall_b;
  assign woff_b = aw_q_b - 32'h4000_0000;
  assign roff_b = araddr_b - 32'h4000_0000;

  always @(posedge clk) begin
    if (areset) begin
      aw_got_b <= 1'b0; w_got_b <= 1'b0; bvalid_b <= 1'b0; rvalid_b <= 1'b0;
      rdata_b <= '0; awready_b <= 1'b0; dly_b <= '0; hold_b <= 1'b0;
    end else begin
      if (hold_b && (!awvalid_b || (awaddr_b != held_addr_b))) stab_err_b <= 1'b1;
      hold_b      <= awvalid_b && !awready_b;
      held_addr_b <= awaddr_b;
      if (awvalid_b && !awready_b) stall_b <= stall_b + 1;
      if (aw_got_b && w_got_b && !bvalid_b) begin
        mem_b[woff_b[5:3]] <= w_q_b;
        obs_waddr_b.push_back(aw_q_b);
        obs_wdata_b.push_back(w_q_b);
        bvalid_b <= 1'b1; aw_got_b <= 1'b0; w_got_b <= 1'b0;
      end
      if (wvalid_b) begin
        w_got_b <= 1'b1; w_q_b <= wdata_b; dly_b <= 3'd3;
      end else if (dly_b != 3'd0) begin
        dly_b <= dly_b - 3'd1;
        if (dly_b == 3'd1) awready_b <= 1'b1;
      end
      if (awvalid_b && awready_b) begin
        aw_got_b <= 1'b1; aw_q_b <= awaddr_b; awready_b <= 1'b0;
      end
      if (bvalid_b && bready_b) bvalid_b <= 1'b0;
      if (rvalid_b && rready_b) rvalid_b <= 1'b0;
      if (arvalid_b) begin
        obs_raddr_b.push_back(araddr_b);
        rdata_b  <= mem_b[roff_b[5:3]];
        rvalid_b <= 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp_a(input int n);
    for (int i = 0; i < n; i++) begin
      exp_waddr_a.push_back(32'h4000_0000 + 32'(4 * i));
      exp_raddr_a.push_back(32'h4000_0000 + 32'(4 * i));
      exp_wdata_a.push_back({32'h0, 32'hDEADBEEF ^ 32'(i)});
    end
  endtask

  task automatic clear_a();
    exp_waddr_a.delete(); obs_waddr_a.delete(); exp_raddr_a.delete();
    obs_raddr_a.delete(); exp_wdata_a.delete(); obs_wdata_a.delete();
  endtask

  task automatic score_a(input string tag);
    check({tag, "_wr_cnt"}, 64'(obs_waddr_a.size()), 64'(exp_waddr_a.size()));
    check({tag, "_rd_cnt"}, 64'(obs_raddr_a.size()), 64'(exp_raddr_a.size()));
    while (exp_waddr_a.size() > 0 && obs_waddr_a.size() > 0)
      check({tag, "_awaddr"}, 64'(obs_waddr_a.pop_front()), 64'(exp_waddr_a.pop_front()));
    while (exp_wdata_a.size() > 0 && obs_wdata_a.size() > 0)
      check({tag, "_wdata"}, obs_wdata_a.pop_front(), exp_wdata_a.pop_front());
    while (exp_raddr_a.size() > 0 && obs_raddr_a.size() > 0)
      check({tag, "_araddr"}, 64'(obs_raddr_a.pop_front()), 64'(exp_raddr_a.pop_front()));
    clear_a();
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n = 0;
    while (!done_a && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done_in_time"}, 64'(done_a), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    areset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    bresp_mode_a = 2'b00; corrupt_a = -1; ar_stall_a = 1'b0;
    stab_err_b = 1'b0; stall_b = 0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);

    check("rst_ctrl_a", 64'({busy_a, done_a, pass_a, timeout_a, err_a, leds_a, awvalid_a,
                             wvalid_a, bready_a, arvalid_a, rready_a}), 64'd0);
    check("rst_bus_a", 64'(|{awaddr_a, wdata_a, wstrb_a, araddr_a}), 64'd0);
    check("rst_ctrl_b", 64'({busy_b, done_b, pass_b, err_b, awvalid_b, arvalid_b}), 64'd0);

    // Test 1: clean run, plus a start pulse mid-run that must be ignored.
    push_exp_a(16);
    pulse_start_a();
    check("t1_busy", 64'(busy_a), 64'd1);
    check("t1_done_low", 64'(done_a), 64'd0);
    repeat (5) @(negedge clk);
    pulse_start_a();
    wait_done_a("t1", 400);
    check("t1_wstrb", 64'(first_wstrb_a), 64'hF);
    check("t1_word0_addr", 64'(obs_waddr_a[0]), 64'h4000_0000);
    check("t1_word0_data", obs_wdata_a[0], 64'hDEADBEEF);
    check("t1_word1_addr", 64'(obs_waddr_a[1]), 64'h4000_0004);
    check("t1_word1_data", obs_wdata_a[1], 64'hDEADBEEE);
    score_a("t1");
    check("t1_err", 64'(err_a), 64'd0);
    check("t1_pass", 64'(pass_a), 64'd1);
    check("t1_leds", 64'(leds_a), 64'b1100);
    check("t1_busy_end", 64'(busy_a), 64'd0);

    // Test 2: slave returns zero for word 3; restart from FIN.
    corrupt_a = 3;
    push_exp_a(16);
    pulse_start_a();
    check("t2_cleared", 64'({done_a, pass_a, err_a}), 64'd0);
    wait_done_a("t2", 400);
    score_a("t2");
    check("t2_err", 64'(err_a), 64'd1);
    check("t2_pass", 64'(pass_a), 64'd0);
    check("t2_leds", 64'(leds_a), 64'b1010);
    corrupt_a = -1;

    // Test 3: every write answered SLVERR.
    bresp_mode_a = 2'b10;
    push_exp_a(16);
    pulse_start_a();
    wait_done_a("t3", 400);
    score_a("t3");
    check("t3_err", 64'(err_a), 64'd16);
    check("t3_pass", 64'(pass_a), 64'd0);
    check("t3_leds", 64'(leds_a), 64'b1010);
    bresp_mode_a = 2'b00;

    // Test 4: 64-bit instance with delayed AWREADY.
    for (int i = 0; i < 4; i++) begin
      exp_waddr_b.push_back(32'h4000_0000 + 32'(8 * i));
      exp_raddr_b.push_back(32'h4000_0000 + 32'(8 * i));
      exp_wdata_b.push_back({2{32'hDEADBEEF ^ 32'(i)}});
    end
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    begin
      int n = 0;
      while (!done_b && n < 400) begin @(negedge clk); n++; end
    end
    check("t4_done_in_time", 64'(done_b), 64'd1);
    check("t4_word1_addr", 64'(obs_waddr_b[1]), 64'h4000_0008);
    check("t4_word2_data", obs_wdata_b[2], 64'hDEADBEED_DEADBEED);
    check("t4_wr_cnt", 64'(obs_waddr_b.size()), 64'd4);
    check("t4_rd_cnt", 64'(obs_raddr_b.size()), 64'd4);
    while (exp_waddr_b.size() > 0 && obs_waddr_b.size() > 0)
      check("t4_awaddr", 64'(obs_waddr_b.pop_front()), 64'(exp_waddr_b.pop_front()));
    while (exp_wdata_b.size() > 0 && obs_wdata_b.size() > 0)
      check("t4_wdata", obs_wdata_b.pop_front(), exp_wdata_b.pop_front());
    while (exp_raddr_b.size() > 0 && obs_raddr_b.size() > 0)
      check("t4_araddr", 64'(obs_raddr_b.pop_front()), 64'(exp_raddr_b.pop_front()));
    check("t4_aw_stalled", 64'(stall_b >= 12), 64'd1);
    check("t4_aw_stable", 64'(stab_err_b), 64'd0);
    check("t4_pass", 64'(pass_b), 64'd1);
    check("t4_err", 64'(err_b), 64'd0);

    // Test 5: reset while word 5 is in RD_DATA, then a clean rerun.
    clear_a();
    pulse_start_a();
    begin
      int n = 0;
      while (!(obs_raddr_a.size() == 6 && rready_a) && n < 400) begin @(negedge clk); n++; end
    end
    check("t5_reached_rd5", 64'(rready_a), 64'd1);
    areset = 1'b1;
    @(negedge clk);
    check("t5_rst_ctrl", 64'({busy_a, done_a, pass_a, timeout_a, err_a, leds_a, awvalid_a,
                              wvalid_a, bready_a, arvalid_a, rready_a}), 64'd0);
    check("t5_rst_bus", 64'(|{awaddr_a, wdata_a, wstrb_a, araddr_a}), 64'd0);
    areset = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_idle_hold", 64'({busy_a, done_a}), 64'd0);
    clear_a();
    push_exp_a(16);
    pulse_start_a();
    wait_done_a("t5", 400);
    score_a("t5");
    check("t5_pass", 64'(pass_a), 64'd1);

`ifdef AXIL_MEM_TEST_TIMEOUT_EN
    // Test 6: ARREADY never rises; watchdog must end the run.
    ar_stall_a = 1'b1;
    pulse_start_a();
    wait_done_a("t6", 2000);
    check("t6_timeout", 64'(timeout_a), 64'd1);
    check("t6_pass", 64'(pass_a), 64'd0);
    check("t6_arvalid", 64'(arvalid_a), 64'd0);
    ar_stall_a = 1'b0;
    clear_a();
`else
    check("t6_timeout_tied", 64'(timeout_a), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
